// File: rtl/seven_segment_scan_controller.sv
// Multiplexed 7-seg driver: double-buffered BCD word, round-robin scan with ghost blanking, leading-zero suppression.
// Outputs registered (1 cycle after counters/display state); load always accepted, no backpressure.
module seven_segment_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done,
  output logic                    update_pending
);
  localparam int SW = $clog2(REFRESH_DIV);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam logic PH_BLANK = 1'b0;
  localparam logic PH_DRIVE = 1'b1;

  logic [SW-1:0]           slot_cnt;
  logic [DW-1:0]           digit_idx;
  logic [4*NUM_DIGITS-1:0] disp, pending;
  logic [NUM_DIGITS-1:0]   disp_dp, pending_dp;
  logic [NUM_DIGITS-1:0]   lz_sup;
  logic                    slot_end, frame_end, phase;
  logic [3:0]              cur_bcd;
  logic                    cur_dp, cur_sup;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1111110;
      4'd1:    decode = 7'b0110000;
      4'd2:    decode = 7'b1101101;
      4'd3:    decode = 7'b1111001;
      4'd4:    decode = 7'b0110011;
      4'd5:    decode = 7'b1011011;
      4'd6:    decode = 7'b1011111;
      4'd7:    decode = 7'b1110000;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1111011;
      default: decode = 7'b0000000;
    endcase
  endfunction

  assign slot_end  = (slot_cnt == SW'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (digit_idx == DW'(NUM_DIGITS - 1));
  assign phase     = (slot_cnt < SW'(BLANK_CYCLES)) ? PH_BLANK : PH_DRIVE;

  // A digit is blank-suppressible when it and every digit above it are zero; digit 0 never is.
  always_comb begin : lz_scan
    logic zero_run;
    zero_run = 1'b1;
    lz_sup   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run  = zero_run & (disp[4*i +: 4] == 4'd0);
      lz_sup[i] = zero_run & (i != 0);
    end
  end

  always_comb begin
    cur_bcd = 4'd0;
    cur_dp  = 1'b0;
    cur_sup = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == DW'(i)) begin
        cur_bcd = disp[4*i +: 4];
        cur_dp  = disp_dp[i];
        cur_sup = lz_sup[i] & blank_lz;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else if (slot_end) begin
      slot_cnt  <= '0;
      digit_idx <= (digit_idx == DW'(NUM_DIGITS - 1)) ? '0 : digit_idx + DW'(1);
    end else begin
      slot_cnt  <= slot_cnt + SW'(1);
    end
  end

  // The displayed word only changes on the frame boundary; a load on that cycle bypasses pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp           <= '0;
      disp_dp        <= '0;
      pending        <= '0;
      pending_dp     <= '0;
      update_pending <= 1'b0;
    end else begin
      if (load) begin
        pending    <= bcd_in;
        pending_dp <= dp_in;
      end
      if (frame_end) begin
        if (load) begin
          disp    <= bcd_in;
          disp_dp <= dp_in;
        end else if (update_pending) begin
          disp    <= pending;
          disp_dp <= pending_dp;
        end
        update_pending <= 1'b0;
      end else if (load) begin
        update_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_sel  <= '1;
      seg        <= '0;
      dp         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (phase == PH_BLANK) begin
        digit_sel <= '1;
        seg       <= '0;
        dp        <= 1'b0;
      end else begin
        digit_sel <= ~(NUM_DIGITS'(1) << digit_idx);
        seg       <= cur_sup ? 7'b0000000 : decode(cur_bcd);
        dp        <= cur_dp;
      end
    end
  end
endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Directed + random stimulus for the scan controller, checked each cycle against a frame-position model.
module tb_seven_segment_scan_controller;
  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BC = 1;
  localparam int FR = ND * RD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          load = 1'b0;
  logic [15:0]   bcd_in = '0;
  logic [3:0]    dp_in = '0;
  logic          blank_lz = 1'b0;
  logic [3:0]    digit_sel;
  logic [6:0]    seg;
  logic          dp;
  logic          frame_done;
  logic          update_pending;

  seven_segment_scan_controller #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .digit_sel(digit_sel), .seg(seg), .dp(dp),
    .frame_done(frame_done), .update_pending(update_pending)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          t;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dp, m_pdp;
  logic        m_upd;
  logic [6:0]  seg_tab [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic model_reset();
    t = 0; m_disp = '0; m_pend = '0; m_dp = '0; m_pdp = '0; m_upd = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sel"}, 32'(digit_sel), 32'hF);
    chk({tag, "_seg"}, 32'(seg), 32'h0);
    chk({tag, "_dp"}, 32'(dp), 32'h0);
    chk({tag, "_fd"}, 32'(frame_done), 32'h0);
    chk({tag, "_upd"}, 32'(update_pending), 32'h0);
  endtask

  // One clock: predict from position in the frame (t cycles since reset), then compare.
  task automatic step();
    int         slot, dig;
    logic [3:0] e_sel, nib;
    logic [6:0] e_seg;
    logic       e_dp, e_fd;
    slot = t % RD;
    dig  = (t / RD) % ND;
    if (slot < BC) begin
      e_sel = 4'hF; e_seg = '0; e_dp = 1'b0;
    end else begin
      e_sel = ~(4'b0001 << dig);
      nib   = m_disp[4*dig +: 4];
      e_seg = (blank_lz && dig != 0 && (m_disp >> (4*dig)) == 0) ? 7'b0 : seg_tab[nib];
      e_dp  = m_dp[dig];
    end
    e_fd = (slot == RD - 1) && (dig == ND - 1);
    if (e_fd) begin
      if (load) begin m_disp = bcd_in; m_dp = dp_in; end
      else if (m_upd) begin m_disp = m_pend; m_dp = m_pdp; end
      m_upd = 1'b0;
    end else if (load) begin
      m_upd = 1'b1;
    end
    if (load) begin m_pend = bcd_in; m_pdp = dp_in; end
    @(posedge clk); #1;
    chk("digit_sel", 32'(digit_sel), 32'(e_sel));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("update_pending", 32'(update_pending), 32'(m_upd));
    t++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    load = 1'b1; bcd_in = v; dp_in = d;
    step();
    load = 1'b0;
  endtask

  task automatic goto_pos(input int pos);
    while (t % FR != pos) step();
  endtask

  initial begin
    seg_tab[0]  = 7'b1111110; seg_tab[1]  = 7'b0110000; seg_tab[2]  = 7'b1101101;
    seg_tab[3]  = 7'b1111001; seg_tab[4]  = 7'b0110011; seg_tab[5]  = 7'b1011011;
    seg_tab[6]  = 7'b1011111; seg_tab[7]  = 7'b1110000; seg_tab[8]  = 7'b1111111;
    seg_tab[9]  = 7'b1111011;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0000000;

    model_reset();
    #1 rst_n = 1'b0;
    #2 chk_reset("reset_init");
    @(negedge clk); rst_n = 1'b1;
    model_reset();

    run(20);

    // Decode sweep on digit 0
    for (int v = 0; v < 16; v++) begin
      do_load(16'(v), 4'b0000);
      run(FR + 1);
    end

    // Scan order with decimal points
    do_load(16'h4321, 4'b0101);
    run(2 * FR);

    // Load at start of digit 1's slot: held until the frame boundary
    goto_pos(RD);
    do_load(16'h1111, 4'b0000);
    run(FR + 4);

    // Load exactly on the boundary cycle overrides an older pending word
    goto_pos(2);
    do_load(16'h5555, 4'b1111);
    goto_pos(FR - 1);
    do_load(16'h9999, 4'b0000);
    run(FR + 4);

    // Leading-zero suppression
    blank_lz = 1'b1;
    do_load(16'h0070, 4'b1000);
    run(2 * FR);
    do_load(16'h0000, 4'b0000);
    run(2 * FR);
    blank_lz = 1'b0;
    run(FR);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      load     = ($urandom_range(7) == 0);
      bcd_in   = 16'($urandom);
      dp_in    = 4'($urandom);
      blank_lz = 1'($urandom_range(1));
      step();
    end
    load = 1'b0;

    // Mid-scan asynchronous reset with a pending word that must be lost
    goto_pos(5);
    do_load(16'h8888, 4'b1111);
    step();
    #2 rst_n = 1'b0;
    #1 chk_reset("reset_mid");
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    run(2 * FR);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
